// File: rtl/uart_pixel_writer.sv
// ---------------------------------------------------------------------------
// uart_pixel_writer
//
// Packs pairs of received UART bytes into 12-bit RGB444 pixels and writes
// them to the frame buffer in raster order, addresses 0..WIDTH*HEIGHT-1.
// The first byte of a pair supplies R in bits [3:0]; bits [7:4] are ignored.
// The second byte supplies G in bits [7:4] and B in bits [3:0].
//
// Ports:
//   clk_100MHz  in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   display     in   1 = VGA read mode: writer held idle, address rewound
//   rx_data     in   [7:0] received byte
//   rx_valid    in   one-cycle strobe qualifying rx_data
//   wr_addr     out  [$clog2(WIDTH*HEIGHT)-1:0] address of current/next pixel
//   wr_pixel    out  [11:0] packed pixel {R,G,B}
//   wr_en       out  one-cycle write strobe
//   frame_done  out  set after the last pixel of a frame is written
//   overrun     out  sticky; a byte arrived after the frame was complete
//
// Optional build macro BYTE_TIMEOUT_EN: abandons a half-received pixel when
// the low byte has not arrived within TIMEOUT_CYCLES, so that byte pairing
// resynchronises after a lost byte. Without it WAIT_LO waits indefinitely.
// ---------------------------------------------------------------------------
module uart_pixel_writer #(
  parameter int WIDTH          = 320,
  parameter int HEIGHT         = 240,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                                clk_100MHz,
  input  logic                                reset,
  input  logic                                display,
  input  logic [7:0]                          rx_data,
  input  logic                                rx_valid,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]     wr_addr,
  output logic [11:0]                         wr_pixel,
  output logic                                wr_en,
  output logic                                frame_done,
  output logic                                overrun
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int AW   = $clog2(WIDTH * HEIGHT);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  localparam logic [1:0] S_WAIT_HI = 2'd0;
  localparam logic [1:0] S_WAIT_LO = 2'd1;
  localparam logic [1:0] S_WRITE   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  // A frame of fewer than two pixels would give a zero-width address bus.
  if (NPIX < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("uart_pixel_writer: WIDTH*HEIGHT must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic [1:0]    state_q, state_d;
  logic [3:0]    hi_q, hi_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [11:0]   pix_q, pix_d;
  logic          wr_en_q, wr_en_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;

`ifdef BYTE_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 20) ? $clog2(TIMEOUT_CYCLES + 1) : 20;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    pix_d   = pix_q;
    wr_en_d = 1'b0;
    done_d  = done_q;
    ovr_d   = ovr_q;
`ifdef BYTE_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    if (display) begin
      // Read mode wins over any incoming byte; flags are left untouched.
      state_d = S_WAIT_HI;
      addr_d  = '0;
      hi_d    = 4'd0;
    end else begin
      case (state_q)
        S_WAIT_HI: begin
          if (rx_valid) begin
            hi_d    = rx_data[3:0];
            done_d  = 1'b0;
            state_d = S_WAIT_LO;
`ifdef BYTE_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
        S_WAIT_LO: begin
          if (rx_valid) begin
            pix_d   = {hi_q, rx_data};
            wr_en_d = 1'b1;
            state_d = S_WRITE;
`ifdef BYTE_TIMEOUT_EN
          end else if (cnt_q == CNT_LAST) begin
            // The count reaches TIMEOUT_CYCLES on this edge with no low byte.
            hi_d    = 4'd0;
            state_d = S_WAIT_HI;
          end else begin
            cnt_d   = cnt_q + 1'b1;
`endif
          end
        end
        S_WRITE: begin
          if (addr_q < LAST_ADDR) begin
            addr_d = addr_q + 1'b1;
            // A byte landing in the write cycle starts the next pixel.
            if (rx_valid) begin
              hi_d    = rx_data[3:0];
              state_d = S_WAIT_LO;
`ifdef BYTE_TIMEOUT_EN
              cnt_d   = '0;
`endif
            end else begin
              state_d = S_WAIT_HI;
            end
          end else begin
            addr_d  = '0;
            done_d  = 1'b1;
            state_d = S_DONE;
            if (rx_valid) ovr_d = 1'b1;
          end
        end
        S_DONE: begin
          if (rx_valid) ovr_d = 1'b1;
        end
        default: state_d = S_WAIT_HI;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q <= S_WAIT_HI;
      hi_q    <= 4'd0;
      addr_q  <= '0;
      pix_q   <= 12'd0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef BYTE_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      pix_q   <= pix_d;
      wr_en_q <= wr_en_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
`ifdef BYTE_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign wr_addr    = addr_q;
  assign wr_pixel   = pix_q;
  assign wr_en      = wr_en_q;
  assign frame_done = done_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_pixel_writer.sv
module tb_uart_pixel_writer;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int NPIX = W * H;

  logic        clk_100MHz = 1'b0;
  logic        reset      = 1'b1;
  logic        display    = 1'b0;
  logic [7:0]  rx_data    = 8'd0;
  logic        rx_valid   = 1'b0;
  logic [2:0]  wr_addr;
  logic [11:0] wr_pixel;
  logic        wr_en;
  logic        frame_done;
  logic        overrun;

  int pass_cnt  = 0;
  int check_cnt = 0;

  // Every observed write, as {addr, pixel}.
  logic [14:0] obs[$];

  uart_pixel_writer #(.WIDTH(W), .HEIGHT(H), .TIMEOUT_CYCLES(10)) dut (
    .clk_100MHz(clk_100MHz),
    .reset     (reset),
    .display   (display),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .wr_addr   (wr_addr),
    .wr_pixel  (wr_pixel),
    .wr_en     (wr_en),
    .frame_done(frame_done),
    .overrun   (overrun)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  always @(negedge clk_100MHz) begin
    if (wr_en === 1'b1) obs.push_back({wr_addr, wr_pixel});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change at the falling edge; they are sampled at the next rising
  // edge, and the task returns at the following falling edge.
  task automatic cyc(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(negedge clk_100MHz);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    display = 1'b0;
    idle(2);
    reset = 1'b0;
    obs.delete();
  endtask

  task automatic test_reset();
    do_reset();
    check_cnt++; if (wr_addr !== 3'd0) $display("FAIL reset_addr: got %0d expected 0", wr_addr); else pass_cnt++;
    check_cnt++; if (wr_pixel !== 12'h000) $display("FAIL reset_pixel: got %h expected 000", wr_pixel); else pass_cnt++;
    check_cnt++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b expected 0", wr_en); else pass_cnt++;
    check_cnt++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b expected 0", frame_done); else pass_cnt++;
    check_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else pass_cnt++;
  endtask

  task automatic test_first_pixel();
    do_reset();
    cyc(1'b1, 8'h0A);
    check_cnt++; if (wr_en !== 1'b0) $display("FAIL first_hi_no_wr: got %b expected 0", wr_en); else pass_cnt++;
    cyc(1'b1, 8'h5C);
    check_cnt++; if (wr_en !== 1'b1) $display("FAIL first_wr_en: got %b expected 1", wr_en); else pass_cnt++;
    check_cnt++; if (wr_pixel !== 12'hA5C) $display("FAIL first_pixel: got %h expected a5c", wr_pixel); else pass_cnt++;
    check_cnt++; if (wr_addr !== 3'd0) $display("FAIL first_addr: got %0d expected 0", wr_addr); else pass_cnt++;
    cyc(1'b0, 8'h00);
    check_cnt++; if (wr_en !== 1'b0) $display("FAIL first_wr_en_pulse: got %b expected 0", wr_en); else pass_cnt++;
    check_cnt++; if (wr_addr !== 3'd1) $display("FAIL first_addr_next: got %0d expected 1", wr_addr); else pass_cnt++;
    check_cnt++; if (wr_pixel !== 12'hA5C) $display("FAIL first_pixel_hold: got %h expected a5c", wr_pixel); else pass_cnt++;
  endtask

  // Random full frame with random spacing (including bytes landing in the
  // write cycle); the reference pairs bytes in order and numbers the pixels.
  task automatic test_frame();
    logic [7:0]  bytes[2*NPIX];
    logic [14:0] exp_w;
    do_reset();
    for (int i = 0; i < 2*NPIX; i++) bytes[i] = 8'($urandom);
    for (int i = 0; i < 2*NPIX; i++) begin
      cyc(1'b1, bytes[i]);
      idle($urandom_range(0, 3));
    end
    idle(3);
    check_cnt++; if (obs.size() !== NPIX) $display("FAIL frame_write_count: got %0d expected %0d", obs.size(), NPIX); else pass_cnt++;
    for (int k = 0; k < NPIX; k++) begin
      exp_w = {3'(k), bytes[2*k][3:0], bytes[2*k+1]};
      check_cnt++;
      if (k >= obs.size() || obs[k] !== exp_w)
        $display("FAIL frame_write_%0d: got %h expected %h", k, (k < obs.size()) ? obs[k] : 15'h7fff, exp_w);
      else pass_cnt++;
    end
    check_cnt++; if (frame_done !== 1'b1) $display("FAIL frame_done_set: got %b expected 1", frame_done); else pass_cnt++;
    check_cnt++; if (wr_addr !== 3'd0) $display("FAIL frame_addr_wrap: got %0d expected 0", wr_addr); else pass_cnt++;
    check_cnt++; if (overrun !== 1'b0) $display("FAIL frame_no_overrun: got %b expected 0", overrun); else pass_cnt++;
    cyc(1'b1, 8'($urandom));
    idle(2);
    check_cnt++; if (overrun !== 1'b1) $display("FAIL overrun_set: got %b expected 1", overrun); else pass_cnt++;
    check_cnt++; if (obs.size() !== NPIX) $display("FAIL overrun_no_write: got %0d writes expected %0d", obs.size(), NPIX); else pass_cnt++;
    display = 1'b1;
    idle(3);
    check_cnt++; if (frame_done !== 1'b1) $display("FAIL display_holds_done: got %b expected 1", frame_done); else pass_cnt++;
    check_cnt++; if (overrun !== 1'b1) $display("FAIL display_holds_overrun: got %b expected 1", overrun); else pass_cnt++;
    display = 1'b0;
    cyc(1'b1, 8'h01);
    check_cnt++; if (frame_done !== 1'b0) $display("FAIL new_upload_clears_done: got %b expected 0", frame_done); else pass_cnt++;
    check_cnt++; if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b expected 1", overrun); else pass_cnt++;
  endtask

  task automatic test_display_drop();
    do_reset();
    cyc(1'b1, 8'h03);
    display = 1'b1;
    idle(2);
    cyc(1'b1, 8'h44);
    display = 1'b0;
    cyc(1'b1, 8'h01);
    cyc(1'b1, 8'h23);
    check_cnt++; if (wr_en !== 1'b1) $display("FAIL display_wr_en: got %b expected 1", wr_en); else pass_cnt++;
    check_cnt++; if (wr_pixel !== 12'h123) $display("FAIL display_pixel: got %h expected 123", wr_pixel); else pass_cnt++;
    check_cnt++; if (wr_addr !== 3'd0) $display("FAIL display_addr: got %0d expected 0", wr_addr); else pass_cnt++;
    idle(2);
    check_cnt++; if (obs.size() !== 1) $display("FAIL display_write_count: got %0d expected 1", obs.size()); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc(1'b1, 8'h0F);
    cyc(1'b1, 8'hFF);
    check_cnt++; if (wr_en !== 1'b1 || wr_pixel !== 12'hFFF || wr_addr !== 3'd0)
      $display("FAIL b2b_first: got en=%b pix=%h addr=%0d expected en=1 pix=fff addr=0", wr_en, wr_pixel, wr_addr);
    else pass_cnt++;
    cyc(1'b1, 8'h01);
    check_cnt++; if (wr_en !== 1'b0 || wr_addr !== 3'd1)
      $display("FAIL b2b_mid: got en=%b addr=%0d expected en=0 addr=1", wr_en, wr_addr);
    else pass_cnt++;
    cyc(1'b1, 8'h02);
    check_cnt++; if (wr_en !== 1'b1 || wr_pixel !== 12'h102 || wr_addr !== 3'd1)
      $display("FAIL b2b_second: got en=%b pix=%h addr=%0d expected en=1 pix=102 addr=1", wr_en, wr_pixel, wr_addr);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 8'($urandom));
      cyc(1'b1, 8'($urandom));
    end
    cyc(1'b1, 8'h0C);
    check_cnt++; if (wr_addr !== 3'd5) $display("FAIL mid_addr_before: got %0d expected 5", wr_addr); else pass_cnt++;
    reset = 1'b1;
    cyc(1'b1, 8'h77);
    reset = 1'b0;
    check_cnt++; if (wr_addr !== 3'd0 || wr_pixel !== 12'h000 || wr_en !== 1'b0 || frame_done !== 1'b0 || overrun !== 1'b0)
      $display("FAIL mid_reset_outputs: got addr=%0d pix=%h en=%b done=%b ovr=%b expected all 0",
               wr_addr, wr_pixel, wr_en, frame_done, overrun);
    else pass_cnt++;
    check_cnt++; if (obs.size() !== 5) $display("FAIL mid_no_partial_write: got %0d expected 5", obs.size()); else pass_cnt++;
    cyc(1'b1, 8'h00);
    cyc(1'b1, 8'h11);
    check_cnt++; if (wr_en !== 1'b1 || wr_addr !== 3'd0 || wr_pixel !== 12'h011)
      $display("FAIL mid_after_reset: got en=%b addr=%0d pix=%h expected en=1 addr=0 pix=011", wr_en, wr_addr, wr_pixel);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    logic [14:0] exp_w;
    // Low byte arriving on the last allowed cycle still pairs in both builds.
    do_reset();
    cyc(1'b1, 8'h01);
    idle(9);
    cyc(1'b1, 8'h55);
    idle(2);
    check_cnt++; if (obs.size() !== 1 || obs[0] !== {3'd0, 12'h155})
      $display("FAIL timeout_edge: got %0d writes first %h expected 1 write 0155", obs.size(), (obs.size() > 0) ? obs[0] : 15'h7fff);
    else pass_cnt++;
    // A full timeout window of silence.
    do_reset();
    cyc(1'b1, 8'h07);
    idle(10);
    cyc(1'b1, 8'h08);
    cyc(1'b1, 8'h9A);
    idle(2);
`ifdef BYTE_TIMEOUT_EN
    exp_w = {3'd0, 12'h89A};
`else
    exp_w = {3'd0, 12'h708};
`endif
    check_cnt++; if (obs.size() !== 1 || obs[0] !== exp_w)
      $display("FAIL timeout_pairing: got %0d writes first %h expected 1 write %h", obs.size(), (obs.size() > 0) ? obs[0] : 15'h7fff, exp_w);
    else pass_cnt++;
  endtask

  initial begin
    idle(1);
    test_reset();
    test_first_pixel();
    test_frame();
    test_display_drop();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    test_frame();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
